// File: rtl/vlc_deserializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : vlc_pkg                                                 |
// | Description : Shared constants and helpers for the VLC receive-path   |
// |               deserializer: bit-order selectors, default word width   |
// |               and a constant-evaluable ceil(log2) function.           |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package vlc_pkg;

  localparam int VLC_MSB_FIRST = 1;
  localparam int VLC_LSB_FIRST = 0;
  localparam int VLC_WORD_W    = 8;

  // ceil(log2(value)); clog2(1) = 0. Usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vlc_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : vlc_deserializer_if                                     |
// | Description : Bundles the serial input side and the word output side  |
// |               of the VLC deserializer.                                |
// |   bit_in/bit_valid  qualified serial stream                           |
// |   flush             drop the partially assembled word                 |
// |   clr_ovf           clear the sticky overflow flag                    |
// |   word_out/par_err  FIFO head data and its parity tag                 |
// |   word_valid/ready  downstream handshake                              |
// |   overflow          sticky word-dropped flag                          |
// |   fill              FIFO occupancy                                    |
// |   Modports: master (stream source / word sink), slave (deserializer). |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
interface vlc_deserializer_if #(
  parameter int WORD_W     = vlc_pkg::VLC_WORD_W,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int FILL_W = vlc_pkg::clog2(FIFO_DEPTH) + 1;

  logic              bit_in;
  logic              bit_valid;
  logic              flush;
  logic              clr_ovf;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              par_err;
  logic              overflow;
  logic [FILL_W-1:0] fill;

  modport master (
    output bit_in, bit_valid, flush, clr_ovf, word_ready,
    input  word_out, word_valid, par_err, overflow, fill
  );

  modport slave (
    input  bit_in, bit_valid, flush, clr_ovf, word_ready,
    output word_out, word_valid, par_err, overflow, fill
  );

endinterface
`default_nettype wire

// File: rtl/vlc_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vlc_sync_fifo                                           |
// | Description : Single-clock FIFO, WIDTH x DEPTH (DEPTH power of 2).    |
// |   clk, rst    clock, asynchronous active-low reset                    |
// |   push, din   write request and data (ignored when full, unless a    |
// |               pop happens on the same edge)                           |
// |   pop         read request (ignored when empty)                       |
// |   dout        head entry, forced to 0 while empty                     |
// |   full, empty, count  status                                          |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module vlc_sync_fifo import vlc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    push,
  input  wire logic [WIDTH-1:0]        din,
  input  wire logic                    pop,
  output logic      [WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic      [clog2(DEPTH):0]   count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // A pop on the same edge frees the slot, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vlc_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vlc_deserializer                                        |
// | Description : Serial-to-parallel converter for the VLC receive path.  |
// |               Assembles WORD_W qualified bits in MSB_FIRST order,     |
// |               queues completed words in a FIFO and hands them out on  |
// |               a valid/ready handshake with sticky overflow reporting. |
// |   clk   system clock                                                  |
// |   rst   asynchronous, active-low reset                                |
// |   bus   vlc_deserializer_if.slave (stream in, words out, status)      |
// | Build option: define VLC_DESER_PARITY_EN to expect one even-parity    |
// |               bit after every word and tag each stored word with      |
// |               par_err; undefined, par_err is tied to 0.               |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module vlc_deserializer import vlc_pkg::*; #(
  parameter int WORD_W     = VLC_WORD_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = VLC_MSB_FIRST
) (
  input wire logic          clk,
  input wire logic          rst,
  vlc_deserializer_if.slave bus
);

  localparam int FILL_W = clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W  = clog2(WORD_W + 1);

`ifdef VLC_DESER_PARITY_EN
  // Data bits occupy counts 0..WORD_W-1, the parity bit count WORD_W.
  localparam int               ENTRY_W  = WORD_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W);
`else
  localparam int               ENTRY_W  = WORD_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);
`endif

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [WORD_W-1:0]  shifted;
  logic               overflow_q, overflow_d;
  logic               done;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic [FILL_W-1:0]  count;

  // Assembly register after accepting bus.bit_in in the configured order.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {sr_q[WORD_W-2:0], bus.bit_in};
    end else begin : g_lsb_first
      assign shifted = {bus.bit_in, sr_q[WORD_W-1:1]};
    end
  endgenerate

  // flush outranks the bit, so a flushed edge never completes a word.
  assign done = bus.bit_valid && !bus.flush && (cnt_q == LAST_CNT);
  assign pop  = !empty && bus.word_ready;

`ifdef VLC_DESER_PARITY_EN
  // The data bits are already in sr_q when the parity bit arrives.
  assign push_data = {(^sr_q) ^ bus.bit_in, sr_q};
`else
  assign push_data = shifted;
`endif

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (bus.flush) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (bus.bit_valid) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        sr_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        sr_d  = shifted;
      end
    end
  end

  // A completion is lost only when the FIFO is full and nothing leaves
  // on the same edge; a set outranks a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (done && full && !pop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      overflow_q <= overflow_d;
    end
  end

  vlc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.word_out   = head[WORD_W-1:0];
  assign bus.word_valid = !empty;
  assign bus.overflow   = overflow_q;
  assign bus.fill       = count;
`ifdef VLC_DESER_PARITY_EN
  assign bus.par_err    = head[WORD_W];
`else
  assign bus.par_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vlc_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_vlc_deserializer                                     |
// | Description : Scoreboard bench for vlc_deserializer. Two instances:   |
// |               dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0). Expected   |
// |               {par_err, word} entries are queued when stimulus is     |
// |               issued; per-instance monitors compare on handshakes.    |
// |               Honours VLC_DESER_PARITY_EN.                            |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_vlc_deserializer;
  import vlc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q_m [$];
  logic [8:0] q_l [$];

  vlc_deserializer_if #(.WORD_W(8), .FIFO_DEPTH(4)) bm ();
  vlc_deserializer_if #(.WORD_W(8), .FIFO_DEPTH(4)) bl ();

  vlc_deserializer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(VLC_MSB_FIRST)) dut_m (
    .clk (clk), .rst (rst), .bus (bm)
  );
  vlc_deserializer #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(VLC_LSB_FIRST)) dut_l (
    .clk (clk), .rst (rst), .bus (bl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && bm.word_valid && bm.word_ready) begin
      if (q_m.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL m_unexpected_word: actual=0x%0h required=none", bm.word_out);
      end else begin
        e = q_m.pop_front();
        chk("m_word", 32'(bm.word_out), 32'(e[7:0]));
        chk("m_par_err", 32'(bm.par_err), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && bl.word_valid && bl.word_ready) begin
      if (q_l.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL l_unexpected_word: actual=0x%0h required=none", bl.word_out);
      end else begin
        e = q_l.pop_front();
        chk("l_word", 32'(bl.word_out), 32'(e[7:0]));
        chk("l_par_err", 32'(bl.par_err), 32'(e[8]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic b, input logic f);
    if (sel) begin
      bl.bit_valid = v; bl.bit_in = b; bl.flush = f;
    end else begin
      bm.bit_valid = v; bm.bit_in = b; bm.flush = f;
    end
  endtask

  // Sends seq[n-1] first down to seq[0], one bit per clock, no gaps.
  task automatic send_bits(input bit sel, input logic [8:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(sel, 1'b1, seq[i], 1'b0);
      tick();
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  // Full on-wire frame for a word: data bits first-to-last, plus good parity if enabled.
  task automatic frame(input logic [7:0] seq, output logic [8:0] f, output int n);
`ifdef VLC_DESER_PARITY_EN
    f = {seq, ^seq};
    n = 9;
`else
    f = {1'b0, seq};
    n = 8;
`endif
  endtask

  task automatic send_word(input bit sel, input logic [7:0] seq);
    logic [8:0] f;
    int n;
    frame(seq, f, n);
    send_bits(sel, f, n);
  endtask

  task automatic expect_m(input logic p, input logic [7:0] w);
    q_m.push_back({p, w});
  endtask

  task automatic expect_l(input logic p, input logic [7:0] w);
    q_l.push_back({p, w});
  endtask

  task automatic wait_drain(input bit sel, input string name);
    for (int k = 0; k < 40; k++) begin
      if ((sel ? bl.fill : bm.fill) == '0) break;
      tick();
    end
    chk(name, sel ? 32'(bl.fill) : 32'(bm.fill), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] f;
    int n;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    bm.clr_ovf = 1'b0; bl.clr_ovf = 1'b0;
    bm.word_ready = 1'b1; bl.word_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_word_valid", 32'(bm.word_valid), 32'd0);
    chk("rst_word_out", 32'(bm.word_out), 32'd0);
    chk("rst_par_err", 32'(bm.par_err), 32'd0);
    chk("rst_overflow", 32'(bm.overflow), 32'd0);
    chk("rst_fill", 32'(bm.fill), 32'd0);
    rst = 1'b1;
    tick();

    // Reset mid-word, with a stored word that must be discarded
    bm.word_ready = 1'b0;
    send_word(1'b0, 8'h77);
    send_bits(1'b0, 9'b0_0001_0110, 5);
    chk("pre_rst_fill", 32'(bm.fill), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_fill", 32'(bm.fill), 32'd0);
    chk("async_rst_valid", 32'(bm.word_valid), 32'd0);
    chk("async_rst_word", 32'(bm.word_out), 32'd0);
    tick();
    rst = 1'b1;
    bm.word_ready = 1'b1;
    tick();

    // 0xA5 after reset: valid appears exactly after the last-bit edge
    expect_m(1'b0, 8'hA5);
    frame(8'hA5, f, n);
    send_bits(1'b0, f >> 1, n - 1);
    chk("lat_valid_before", 32'(bm.word_valid), 32'd0);
    send_bits(1'b0, f, 1);
    chk("lat_valid_after", 32'(bm.word_valid), 32'd1);
    chk("lat_overflow", 32'(bm.overflow), 32'd0);
    wait_drain(1'b0, "drain_a5");

    // Bit order
    expect_l(1'b0, 8'hA5);
    send_word(1'b1, 8'b1010_0101);
    expect_m(1'b0, 8'hA5);
    send_word(1'b0, 8'b1010_0101);
    expect_l(1'b0, 8'h01);
    send_word(1'b1, 8'b1000_0000);
    expect_m(1'b0, 8'h80);
    send_word(1'b0, 8'b1000_0000);
    wait_drain(1'b1, "drain_order_l");
    wait_drain(1'b0, "drain_order_m");

    // Overflow: five words into a four-deep FIFO
    bm.word_ready = 1'b0;
    expect_m(1'b0, 8'h11); expect_m(1'b0, 8'h22);
    expect_m(1'b0, 8'h33); expect_m(1'b0, 8'h44);
    send_word(1'b0, 8'h11); send_word(1'b0, 8'h22); send_word(1'b0, 8'h33);
    send_word(1'b0, 8'h44);
    chk("ovf_before_5th", 32'(bm.overflow), 32'd0);
    send_word(1'b0, 8'h55);
    chk("ovf_fill", 32'(bm.fill), 32'd4);
    chk("ovf_flag", 32'(bm.overflow), 32'd1);
    chk("ovf_head_held", 32'(bm.word_out), 32'h11);
    bm.clr_ovf = 1'b1;
    tick();
    bm.clr_ovf = 1'b0;
    chk("clr_ovf_flag", 32'(bm.overflow), 32'd0);
    chk("clr_ovf_fill", 32'(bm.fill), 32'd4);

    // Full FIFO with a pop on the completing edge
    expect_m(1'b0, 8'h66);
    frame(8'h66, f, n);
    send_bits(1'b0, f >> 1, n - 1);
    bm.word_ready = 1'b1;
    send_bits(1'b0, f, 1);
    chk("fullpop_fill", 32'(bm.fill), 32'd4);
    chk("fullpop_overflow", 32'(bm.overflow), 32'd0);
    wait_drain(1'b0, "drain_fullpop");
    chk("fullpop_queue_empty", 32'(q_m.size()), 32'd0);

    // Overflow set outranks a simultaneous clear
    bm.word_ready = 1'b0;
    expect_m(1'b0, 8'h77); expect_m(1'b0, 8'h88);
    expect_m(1'b0, 8'h99); expect_m(1'b0, 8'hAA);
    send_word(1'b0, 8'h77); send_word(1'b0, 8'h88);
    send_word(1'b0, 8'h99); send_word(1'b0, 8'hAA);
    frame(8'hBB, f, n);
    send_bits(1'b0, f >> 1, n - 1);
    bm.clr_ovf = 1'b1;
    send_bits(1'b0, f, 1);
    bm.clr_ovf = 1'b0;
    chk("set_wins_overflow", 32'(bm.overflow), 32'd1);
    bm.clr_ovf = 1'b1;
    tick();
    bm.clr_ovf = 1'b0;
    bm.word_ready = 1'b1;
    wait_drain(1'b0, "drain_setwins");

    // Flush priority over a coincident bit; queued data survives
    bm.word_ready = 1'b0;
    expect_m(1'b0, 8'h5A);
    send_word(1'b0, 8'h5A);
    send_bits(1'b0, 9'b0_0000_0101, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    expect_m(1'b0, 8'h3C);
    send_word(1'b0, 8'h3C);
    chk("flush_fill", 32'(bm.fill), 32'd2);
    chk("flush_head", 32'(bm.word_out), 32'h5A);
    bm.word_ready = 1'b1;
    wait_drain(1'b0, "drain_flush");

`ifdef VLC_DESER_PARITY_EN
    // Parity tagging
    bm.word_ready = 1'b0;
    expect_m(1'b0, 8'h0F);
    send_bits(1'b0, {8'h0F, 1'b0}, 9);
    expect_m(1'b1, 8'h0F);
    send_bits(1'b0, {8'h0F, 1'b1}, 9);
    expect_m(1'b0, 8'h03);
    send_word(1'b0, 8'h03);
    // Flush while the parity bit is pending
    send_bits(1'b0, {8'hFF, 1'b0}, 8);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    expect_m(1'b0, 8'h12);
    send_word(1'b0, 8'h12);
    chk("par_fill", 32'(bm.fill), 32'd4);
    bm.word_ready = 1'b1;
    wait_drain(1'b0, "drain_parity");
`endif

    // Ready with an empty FIFO has no effect
    tick();
    chk("empty_ready_fill", 32'(bm.fill), 32'd0);
    chk("final_queue_m", 32'(q_m.size()), 32'd0);
    chk("final_queue_l", 32'(q_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
